ex_pipe_slice: RTL and testbench
================================

# ex_pipe_slice

Datapath slice of the 5-stage 64-bit ARM (LEGv8-subset) pipeline. It contains three parts:
- the IF→RF pipeline register;
- the execute-stage ALU with its operand-B select and the condition-flag register;
- the EX→MEM pipeline register.

It sits between instruction fetch/decode and the data-memory stage. Forwarding and branch logic use its combinational ALU result and N/V outputs in the same cycle.

## Interface
Parameters:
- None. Data width is fixed at 64 bits and instruction width at 32 bits.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low (0 = reset, sampled on posedge clk).
- if_instr  in  32  fetched instruction.
- if_pc  in  64  PC of the fetched instruction.
- if_pc_plus4  in  64  fetch PC + 4.
- rf_instr  out  32  registered if_instr.
- rf_pc  out  64  registered if_pc.
- rf_pc_plus4  out  64  registered if_pc_plus4.
- ex_data_a  in  64  ALU operand A (already forwarded).
- ex_data_b  in  64  register operand B (already forwarded); also the store data.
- ex_instr  in  32  instruction in EX; immediate source.
- ex_is_addi  in  1  select Imm12 when ex_alu_src=1.
- ex_alu_src  in  1  0 = register B; 1 = immediate.
- ex_alu_op  in  3  ALU operation.
- ex_flag_en  in  1  load the flag register this cycle.
- ex_ctrl  in  mem_ctrl_t  {mem_write, mem_to_reg[1:0], read_en, reg_write, reg3loc}.
- ex_pc_plus4  in  64  PC+4 of the EX instruction.
- alu_result  out  64  combinational ALU result.
- negative  out  1  combinational alu_result[63].
- overflow  out  1  combinational signed overflow of the current op.
- flags_q  out  4  registered flags {N,Z,V,C}.
- mem_ctrl  out  mem_ctrl_t  registered ex_ctrl.
- mem_instr  out  32  registered ex_instr.
- mem_alu_result  out  64  registered alu_result.
- mem_data_b  out  64  registered ex_data_b (not the muxed operand).
- mem_pc_plus4  out  64  registered ex_pc_plus4.

## Operation
Operand B:
- ex_alu_src=0: B = ex_data_b.
- ex_alu_src=1, ex_is_addi=1: B = zero-extend(ex_instr[21:10]).
- ex_alu_src=1, ex_is_addi=0: B = sign-extend(ex_instr[20:12]).

ALU ops:
- 000: pass B.
- 010: A+B.
- 011: A+~B+1.
- 100: AND.
- 101: OR.
- 110: XOR.
- 001 and 111: result 0.

Flags:
- N = result[63].
- Z = (result == 0).
- C = carry out of bit 63 for add/sub, else 0.
- V = signed overflow for add/sub, else 0.

Outputs:
- negative and overflow are always driven from the current op, regardless of ex_flag_en.
- flags_q loads {N,Z,V,C} only when ex_flag_en=1; otherwise it holds.

## Timing
- All three register groups capture on posedge clk, one cycle of latency each. There are no stalls and no enables other than ex_flag_en.
- ALU path is purely combinational from the ex_* inputs to alu_result, negative and overflow in the same cycle.
- reset=0 at a clock edge clears all registers to zero: rf_*, mem_*, mem_ctrl and flags_q. The reset value of mem_ctrl is all-zero, so no write or read occurs.
- Reset has priority over ex_flag_en.
- Reset asserted mid-stream discards in-flight contents on that edge. The first edge after reset=1 captures live inputs.
- Flag write and flag read in the same cycle: flags_q shows the old value until the edge.

## Structure
Package cpu_pkg holds:
- mem_ctrl_t, a packed struct of 6 bits;
- the ALU op localparams (ALU_PASSB, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR);
- the flag index constants.

Sub-module alu64 is purely combinational: a, b, op → result, n, z, v, c. The pipeline registers and flag register are written inline with always_ff.

## Test plan
- Reset: drive nonzero inputs and hold reset=0 for 2 edges → all rf_*, mem_* and flags_q = 0. Release → after 1 edge, rf_instr = if_instr (e.g. 0xDEADBEEF) and rf_pc = 0x40.
- ADD: a=5, b=7, op=010, src=0, flag_en=1 → alu_result=12 in the same cycle. Next edge: mem_alu_result=12, flags_q=0000.
- SUB/hold: a=3, b=3, op=011, flag_en=1 → flags_q = {N0,Z1,V0,C1}. Next cycle a=1, b=2, flag_en=0 → alu_result=0xFFFF_FFFF_FFFF_FFFF and negative=1, with flags_q unchanged.
- Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, ADD → result 0x8000_0000_0000_0000, negative=1, overflow=1, C=0.
- Immediates: src=1, is_addi=0, instr[20:12]=0x1FF, a=10, ADD → 9. Then is_addi=1, instr[21:10]=0xFFF → 4105. In both cases mem_data_b = ex_data_b.
- EX→MEM: ex_ctrl=6'b110101 and ex_pc_plus4=0x104 → mem_ctrl=6'b110101 and mem_pc_plus4=0x104 after exactly 1 edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 execute-stage datapath slice.
//   mem_ctrl_t : memory/writeback control bundle carried from EX to MEM
//   ALU_*      : ALU operation encodings (001 and 111 produce zero)
//   FLAG_*     : bit positions of {N,Z,V,C} inside the 4-bit flag register
package cpu_pkg;

  typedef struct packed {
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       read_en;
    logic       reg_write;
    logic       reg3loc;
  } mem_ctrl_t;

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu64.sv
// Purely combinational 64-bit ALU.
//   a, b   : operands
//   op     : ALU_* encoding from cpu_pkg
//   result : operation result
//   n, z   : result sign / result-is-zero
//   v, c   : signed overflow / carry out of bit 63 (add and sub only, else 0)
module alu64
  import cpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [2:0]  op,
  output logic [63:0] result,
  output logic        n,
  output logic        z,
  output logic        v,
  output logic        c
);

  logic        is_sub;
  logic [63:0] b_eff;
  logic [64:0] sum;

  always_comb begin
    // Subtract shares the adder: A + ~B + 1.
    is_sub = (op == ALU_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {64'd0, is_sub};

    result = '0;
    v      = 1'b0;
    c      = 1'b0;
    case (op)
      ALU_PASSB: result = b;
      ALU_ADD, ALU_SUB: begin
        result = sum[63:0];
        c      = sum[64];
        // Overflow when both adder inputs share a sign the result lacks.
        v      = (a[63] == b_eff[63]) && (sum[63] != a[63]);
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      default:   result = '0;
    endcase

    n = result[63];
    z = (result == 64'd0);
  end

endmodule

// File: rtl/ex_pipe_slice.sv
// Datapath slice of the 5-stage LEGv8 pipeline: IF->RF register, execute
// ALU with operand-B select and flag register, and the EX->MEM register.
//   clk, reset           : clock; synchronous active-low reset
//   if_* -> rf_*         : fetch-to-decode pipeline register
//   ex_data_a/b, ex_instr, ex_is_addi, ex_alu_src, ex_alu_op : ALU inputs
//   alu_result, negative, overflow : combinational ALU outputs (same cycle)
//   ex_flag_en -> flags_q : {N,Z,V,C} register, loads only when enabled
//   ex_ctrl, ex_instr, alu_result, ex_data_b, ex_pc_plus4 -> mem_* : EX->MEM
module ex_pipe_slice
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic [63:0] if_pc,
  input  logic [63:0] if_pc_plus4,
  output logic [31:0] rf_instr,
  output logic [63:0] rf_pc,
  output logic [63:0] rf_pc_plus4,
  input  logic [63:0] ex_data_a,
  input  logic [63:0] ex_data_b,
  input  logic [31:0] ex_instr,
  input  logic        ex_is_addi,
  input  logic        ex_alu_src,
  input  logic [2:0]  ex_alu_op,
  input  logic        ex_flag_en,
  input  mem_ctrl_t   ex_ctrl,
  input  logic [63:0] ex_pc_plus4,
  output logic [63:0] alu_result,
  output logic        negative,
  output logic        overflow,
  output logic [3:0]  flags_q,
  output mem_ctrl_t   mem_ctrl,
  output logic [31:0] mem_instr,
  output logic [63:0] mem_alu_result,
  output logic [63:0] mem_data_b,
  output logic [63:0] mem_pc_plus4
);

  logic [63:0] opb;
  logic        alu_n, alu_z, alu_v, alu_c;

  logic [31:0] rf_instr_q, rf_instr_d;
  logic [63:0] rf_pc_q, rf_pc_d;
  logic [63:0] rf_pc_plus4_q, rf_pc_plus4_d;
  logic [3:0]  flag_reg_q, flag_reg_d;
  mem_ctrl_t   mem_ctrl_q, mem_ctrl_d;
  logic [31:0] mem_instr_q, mem_instr_d;
  logic [63:0] mem_alu_result_q, mem_alu_result_d;
  logic [63:0] mem_data_b_q, mem_data_b_d;
  logic [63:0] mem_pc_plus4_q, mem_pc_plus4_d;

  // ADDI/SUBI use a zero-extended Imm12; loads/stores use a signed DT9 offset.
  always_comb begin
    opb = ex_data_b;
    if (ex_alu_src) begin
      if (ex_is_addi) opb = {52'd0, ex_instr[21:10]};
      else            opb = {{55{ex_instr[20]}}, ex_instr[20:12]};
    end
  end

  alu64 u_alu (
    .a      (ex_data_a),
    .b      (opb),
    .op     (ex_alu_op),
    .result (alu_result),
    .n      (alu_n),
    .z      (alu_z),
    .v      (alu_v),
    .c      (alu_c)
  );

  assign negative = alu_n;
  assign overflow = alu_v;

  always_comb begin
    rf_instr_d       = if_instr;
    rf_pc_d          = if_pc;
    rf_pc_plus4_d    = if_pc_plus4;
    mem_ctrl_d       = ex_ctrl;
    mem_instr_d      = ex_instr;
    mem_alu_result_d = alu_result;
    // Store data is the raw register operand, never the immediate.
    mem_data_b_d     = ex_data_b;
    mem_pc_plus4_d   = ex_pc_plus4;
    flag_reg_d       = flag_reg_q;
    if (ex_flag_en) begin
      flag_reg_d[FLAG_N] = alu_n;
      flag_reg_d[FLAG_Z] = alu_z;
      flag_reg_d[FLAG_V] = alu_v;
      flag_reg_d[FLAG_C] = alu_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_instr_q       <= '0;
      rf_pc_q          <= '0;
      rf_pc_plus4_q    <= '0;
      flag_reg_q       <= '0;
      mem_ctrl_q       <= '0;
      mem_instr_q      <= '0;
      mem_alu_result_q <= '0;
      mem_data_b_q     <= '0;
      mem_pc_plus4_q   <= '0;
    end else begin
      rf_instr_q       <= rf_instr_d;
      rf_pc_q          <= rf_pc_d;
      rf_pc_plus4_q    <= rf_pc_plus4_d;
      flag_reg_q       <= flag_reg_d;
      mem_ctrl_q       <= mem_ctrl_d;
      mem_instr_q      <= mem_instr_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_data_b_q     <= mem_data_b_d;
      mem_pc_plus4_q   <= mem_pc_plus4_d;
    end
  end

  assign rf_instr       = rf_instr_q;
  assign rf_pc          = rf_pc_q;
  assign rf_pc_plus4    = rf_pc_plus4_q;
  assign flags_q        = flag_reg_q;
  assign mem_ctrl       = mem_ctrl_q;
  assign mem_instr      = mem_instr_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_data_b     = mem_data_b_q;
  assign mem_pc_plus4   = mem_pc_plus4_q;

endmodule

// File: tb/tb_ex_pipe_slice.sv
module tb_ex_pipe_slice;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] if_instr;
  logic [63:0] if_pc, if_pc_plus4;
  logic [31:0] rf_instr;
  logic [63:0] rf_pc, rf_pc_plus4;
  logic [63:0] ex_data_a, ex_data_b;
  logic [31:0] ex_instr;
  logic        ex_is_addi, ex_alu_src, ex_flag_en;
  logic [2:0]  ex_alu_op;
  mem_ctrl_t   ex_ctrl;
  logic [63:0] ex_pc_plus4;
  logic [63:0] alu_result;
  logic        negative, overflow;
  logic [3:0]  flags_q;
  mem_ctrl_t   mem_ctrl;
  logic [31:0] mem_instr;
  logic [63:0] mem_alu_result, mem_data_b, mem_pc_plus4;

  int checks = 0;
  int failures = 0;

  ex_pipe_slice dut (
    .clk(clk), .reset(reset),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .rf_instr(rf_instr), .rf_pc(rf_pc), .rf_pc_plus4(rf_pc_plus4),
    .ex_data_a(ex_data_a), .ex_data_b(ex_data_b), .ex_instr(ex_instr),
    .ex_is_addi(ex_is_addi), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_flag_en(ex_flag_en), .ex_ctrl(ex_ctrl), .ex_pc_plus4(ex_pc_plus4),
    .alu_result(alu_result), .negative(negative), .overflow(overflow),
    .flags_q(flags_q), .mem_ctrl(mem_ctrl), .mem_instr(mem_instr),
    .mem_alu_result(mem_alu_result), .mem_data_b(mem_data_b),
    .mem_pc_plus4(mem_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: operand B from the immediate rules, using plain arithmetic.
  function automatic logic [63:0] ref_opb(input logic [63:0] b, input logic [31:0] instr,
                                          input logic src, input logic addi);
    longint imm;
    if (!src) return b;
    if (addi) return 64'((instr >> 10) & 32'hFFF);
    imm = longint'((instr >> 12) & 32'h1FF);
    if (imm >= 256) imm = imm - 512;
    return 64'(imm);
  endfunction

  localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
  localparam logic signed [65:0] SMIN = -66'sd9223372036854775808;

  // Reference ALU: add/sub judged by exact signed/unsigned arithmetic ranges.
  task automatic ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                         output logic [63:0] res, output logic [3:0] nzvc);
    logic signed [65:0] sa, sb, s;
    logic [64:0] wide;
    logic v, c;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'd0: res = b;
      3'd2: begin
        wide = {1'b0, a} + {1'b0, b};
        res = wide[63:0];
        c = wide[64];
        s = sa + sb;
        v = (s > SMAX) || (s < SMIN);
      end
      3'd3: begin
        res = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > SMAX) || (s < SMIN);
      end
      3'd4: res = a & b;
      3'd5: res = a | b;
      3'd6: res = a ^ b;
      default: res = 64'd0;
    endcase
    nzvc = {res[63], res == 64'd0, v, c};
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] instr;
    logic        addi;
    logic        src;
    logic [2:0]  op;
    logic [63:0] exp_res;
    logic        exp_neg;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [63:0] eres;
    logic [3:0]  enzvc, model_flags;
    logic [31:0] e_rf_instr, e_mem_instr;
    logic [63:0] e_rf_pc, e_rf_pc4, e_mem_res, e_mem_b, e_mem_pc4;
    logic [5:0]  e_ctrl, ctrl_pat;

    vecs[0]  = '{64'd5, 64'd7, 32'h0, 1'b0, 1'b0, ALU_ADD, 64'd12, 1'b0, 1'b0};
    vecs[1]  = '{64'd1, 64'd2, 32'h0, 1'b0, 1'b0, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 32'h0, 1'b0, 1'b0, ALU_ADD,
                 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[3]  = '{64'd10, 64'h55, 32'h001F_F000, 1'b0, 1'b1, ALU_ADD, 64'd9, 1'b0, 1'b0};
    vecs[4]  = '{64'd10, 64'h55, 32'h003F_FC00, 1'b1, 1'b1, ALU_ADD, 64'd4105, 1'b0, 1'b0};
    vecs[5]  = '{64'd1, 64'hAA, 32'h0, 1'b0, 1'b0, ALU_PASSB, 64'hAA, 1'b0, 1'b0};
    vecs[6]  = '{64'hF0F0, 64'hFF00, 32'h0, 1'b0, 1'b0, ALU_AND, 64'hF000, 1'b0, 1'b0};
    vecs[7]  = '{64'hF0F0, 64'hFF00, 32'h0, 1'b0, 1'b0, ALU_OR, 64'hFFF0, 1'b0, 1'b0};
    vecs[8]  = '{64'hF0F0, 64'hFF00, 32'h0, 1'b0, 1'b0, ALU_XOR, 64'h0FF0, 1'b0, 1'b0};
    vecs[9]  = '{64'd5, 64'd7, 32'h0, 1'b0, 1'b0, 3'b001, 64'd0, 1'b0, 1'b0};
    vecs[10] = '{64'd5, 64'd7, 32'h0, 1'b0, 1'b0, 3'b111, 64'd0, 1'b0, 1'b0};
    vecs[11] = '{64'h8000_0000_0000_0000, 64'd1, 32'h0, 1'b0, 1'b0, ALU_SUB,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};

    // Reset with nonzero inputs held for two edges.
    reset = 1'b0;
    if_instr = 32'h1234_5678; if_pc = 64'h100; if_pc_plus4 = 64'h104;
    ex_data_a = 64'd5; ex_data_b = 64'd9; ex_instr = 32'hFFFF_FFFF;
    ex_is_addi = 1'b0; ex_alu_src = 1'b0; ex_alu_op = ALU_ADD; ex_flag_en = 1'b1;
    ex_ctrl = mem_ctrl_t'(6'b111111); ex_pc_plus4 = 64'h200;
    tick();
    tick();
    chk("rst_rf_instr", 64'(rf_instr), 64'd0);
    chk("rst_rf_pc", rf_pc, 64'd0);
    chk("rst_rf_pc4", rf_pc_plus4, 64'd0);
    chk("rst_flags", 64'(flags_q), 64'd0);
    chk("rst_mem_ctrl", {58'd0, mem_ctrl}, 64'd0);
    chk("rst_mem_instr", 64'(mem_instr), 64'd0);
    chk("rst_mem_res", mem_alu_result, 64'd0);
    chk("rst_mem_b", mem_data_b, 64'd0);
    chk("rst_mem_pc4", mem_pc_plus4, 64'd0);

    reset = 1'b1;
    if_instr = 32'hDEAD_BEEF; if_pc = 64'h40; if_pc_plus4 = 64'h44;
    ex_flag_en = 1'b0;
    tick();
    chk("rel_rf_instr", 64'(rf_instr), 64'hDEAD_BEEF);
    chk("rel_rf_pc", rf_pc, 64'h40);
    chk("rel_rf_pc4", rf_pc_plus4, 64'h44);
    chk("rel_flags_hold", 64'(flags_q), 64'd0);

    // Table: combinational ALU and operand select, then EX->MEM capture.
    for (int i = 0; i < 12; i++) begin
      ex_data_a = vecs[i].a; ex_data_b = vecs[i].b; ex_instr = vecs[i].instr;
      ex_is_addi = vecs[i].addi; ex_alu_src = vecs[i].src; ex_alu_op = vecs[i].op;
      ex_flag_en = 1'b0;
      #1;
      chk($sformatf("vec%0d_result", i), alu_result, vecs[i].exp_res);
      chk($sformatf("vec%0d_neg", i), 64'(negative), 64'(vecs[i].exp_neg));
      chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ovf));
      tick();
      chk($sformatf("vec%0d_mem_res", i), mem_alu_result, vecs[i].exp_res);
      chk($sformatf("vec%0d_mem_b", i), mem_data_b, vecs[i].b);
    end

    // ADD with flag load, then SUB to zero, then a non-loading SUB.
    ex_alu_src = 1'b0; ex_is_addi = 1'b0;
    ex_data_a = 64'd5; ex_data_b = 64'd7; ex_alu_op = ALU_ADD; ex_flag_en = 1'b1;
    tick();
    chk("add_flags", 64'(flags_q), 64'b0000);
    ex_data_a = 64'd3; ex_data_b = 64'd3; ex_alu_op = ALU_SUB; ex_flag_en = 1'b1;
    #1;
    chk("sub_flags_old_before_edge", 64'(flags_q), 64'b0000);
    tick();
    chk("sub_flags", 64'(flags_q), 64'b0101);
    ex_data_a = 64'd1; ex_data_b = 64'd2; ex_flag_en = 1'b0;
    #1;
    chk("hold_result", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("hold_negative", 64'(negative), 64'd1);
    tick();
    chk("hold_flags", 64'(flags_q), 64'b0101);

    // Overflow with flag load: N=1 Z=0 V=1 C=0.
    ex_data_a = 64'h7FFF_FFFF_FFFF_FFFF; ex_data_b = 64'd1; ex_alu_op = ALU_ADD;
    ex_flag_en = 1'b1;
    tick();
    chk("ovf_flags", 64'(flags_q), 64'b1010);

    // Reset beats flag enable; then EX->MEM control capture after one edge.
    reset = 1'b0;
    tick();
    chk("rst_prio_flags", 64'(flags_q), 64'd0);
    reset = 1'b1; ex_flag_en = 1'b0;
    ctrl_pat = 6'b110101;
    ex_ctrl = mem_ctrl_t'(ctrl_pat); ex_pc_plus4 = 64'h104; ex_instr = 32'hCAFE_0001;
    #1;
    chk("ctrl_not_yet", {58'd0, mem_ctrl}, 64'd0);
    tick();
    chk("ctrl_mem_ctrl", {58'd0, mem_ctrl}, 64'(ctrl_pat));
    chk("ctrl_mem_pc4", mem_pc_plus4, 64'h104);
    chk("ctrl_mem_instr", 64'(mem_instr), 64'hCAFE_0001);

    // Randomized stream against the reference model.
    model_flags = 4'd0;
    for (int n = 0; n < 300; n++) begin
      reset = (n == 0 || $urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      if_instr = $urandom; if_pc = {$urandom, $urandom}; if_pc_plus4 = {$urandom, $urandom};
      ex_data_a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ex_data_b = ex_data_a;
        1: ex_data_b = {$urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000, $urandom};
        default: ex_data_b = {$urandom, $urandom};
      endcase
      ex_instr = $urandom;
      ex_is_addi = 1'($urandom_range(0, 1));
      ex_alu_src = 1'($urandom_range(0, 1));
      ex_alu_op = 3'($urandom_range(0, 7));
      ex_flag_en = 1'($urandom_range(0, 1));
      ex_ctrl = mem_ctrl_t'(6'($urandom_range(0, 63)));
      ex_pc_plus4 = {$urandom, $urandom};
      #1;
      ref_alu(ex_data_a, ref_opb(ex_data_b, ex_instr, ex_alu_src, ex_is_addi),
              ex_alu_op, eres, enzvc);
      chk("rnd_result", alu_result, eres);
      chk("rnd_negative", 64'(negative), 64'(enzvc[3]));
      chk("rnd_overflow", 64'(overflow), 64'(enzvc[1]));
      chk("rnd_flags_pre", 64'(flags_q), 64'(model_flags));
      if (!reset) begin
        model_flags = 4'd0;
        e_rf_instr = '0; e_rf_pc = '0; e_rf_pc4 = '0; e_ctrl = '0;
        e_mem_instr = '0; e_mem_res = '0; e_mem_b = '0; e_mem_pc4 = '0;
      end else begin
        if (ex_flag_en) model_flags = enzvc;
        e_rf_instr = if_instr; e_rf_pc = if_pc; e_rf_pc4 = if_pc_plus4;
        e_ctrl = 6'(ex_ctrl); e_mem_instr = ex_instr; e_mem_res = eres;
        e_mem_b = ex_data_b; e_mem_pc4 = ex_pc_plus4;
      end
      tick();
      chk("rnd_rf_instr", 64'(rf_instr), 64'(e_rf_instr));
      chk("rnd_rf_pc", rf_pc, e_rf_pc);
      chk("rnd_rf_pc4", rf_pc_plus4, e_rf_pc4);
      chk("rnd_flags", 64'(flags_q), 64'(model_flags));
      chk("rnd_mem_ctrl", {58'd0, mem_ctrl}, 64'(e_ctrl));
      chk("rnd_mem_instr", 64'(mem_instr), 64'(e_mem_instr));
      chk("rnd_mem_res", mem_alu_result, e_mem_res);
      chk("rnd_mem_b", mem_data_b, e_mem_b);
      chk("rnd_mem_pc4", mem_pc_plus4, e_mem_pc4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
